flex_adc_feed: RTL and testbench

- Upstream stage of the glove servo channel: reads one flex-sensor channel from an MCP3202 12-bit SPI ADC at a fixed rate.
- Averages a power-of-two number of samples and scales the result to the 15-bit position word.
- The position word drives the 15-bit position input of the SG90 PWM stage (0 = 0°, 32767 ≈ 180°).
- Runs on the 50 MHz system clock.

---
 rtl/flex_adc_feed.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_flex_adc_feed.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_adc_feed.sv
// flex_adc_feed
//   Reads one single-ended channel of an MCP3202 12-bit SPI ADC at a fixed
//   rate, averages 2^AVG_LOG2 conversions and scales the mean to the 15-bit
//   position word consumed by the SG90 PWM stage (0 = 0 deg, 32767 ~ 180 deg).
//
// Optional build macro:
//   SLEW_LIMIT_EN  POS moves toward the new target by at most MAX_STEP per
//                  update. When undefined, POS jumps straight to the target.
//
// Ports:
//   CLK        in   system clock, 50 MHz
//   RST_N      in   asynchronous reset, active-low (released synchronously)
//   ENABLE     in   1 = periodic sampling runs
//   ADC_MISO   in   ADC data out, asynchronous to CLK
//   ADC_CS_N   out  ADC chip select, active-low
//   ADC_SCLK   out  SPI clock, mode 0 (idles low)
//   ADC_MOSI   out  ADC data in (start, SGL, channel, MSBF)
//   POS[14:0]  out  position word to the servo PWM stage
//   POS_VALID  out  one-cycle pulse when POS updates
//   SAMPLE     out  last raw 12-bit conversion (debug)
//
// FSM states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | CS_N high, waiting for a start tick from the period counter
//   ST_SETUP | CS_N low, CLK_DIV cycles of CS-to-SCLK setup
//   ST_SHIFT | 17 SCLK pulses; command out on MOSI, D11..D0 in on MISO
//   ST_HOLD  | SCLK low, CLK_DIV cycles before CS_N is released
//   ST_ACCUM | one cycle: accumulate SAMPLE, update POS when the set is full

module flex_adc_feed #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 50_000,
    parameter int AVG_LOG2      = 2,
    parameter int CHANNEL       = 0,
    parameter int MAX_STEP      = 512
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        ADC_MISO,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_MOSI,
    output logic [14:0] POS,
    output logic        POS_VALID,
    output logic [11:0] SAMPLE
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(1 << AVG_LOG2);
    localparam logic [4:0]       LAST_BIT   = 5'd16;
    localparam logic [4:0]       FIRST_DATA = 5'd5;
    localparam logic [14:0]      POS_RESET  = 15'd16384;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_ACCUM
    } state_t;

    state_t state_q, state_d;

    logic             rst_s1_q, rst_s2_q;
    logic             rst_int_n;
    logic             miso_s1_q, miso_s2_q;

    logic [PER_W-1:0] per_q, per_d;
    logic             tick;

    logic [DIV_W-1:0] div_q, div_d;
    logic             div_zero;
    logic             phase_q, phase_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic [4:0]       bit_idx_inc;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic [11:0]      shift_q, shift_d;
    logic [11:0]      sample_q, sample_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [14:0]      pos_q, pos_d;
    logic             pos_valid_q, pos_valid_d;
    logic             abort_q, abort_d;

    logic [11:0]      avg;
    logic [14:0]      target;
    logic [14:0]      pos_next;

    // Command bit driven during each SCLK pulse: start, SGL, channel, MSBF.
    function automatic logic mosi_bit(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd1, 5'd3: return 1'b1;
            5'd2:             return (CHANNEL != 0);
            default:          return 1'b0;
        endcase
    endfunction

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_s1_q <= 1'b0;
            rst_s2_q <= 1'b0;
        end else begin
            rst_s1_q <= 1'b1;
            rst_s2_q <= rst_s1_q;
        end
    end

    assign rst_int_n = rst_s2_q;

    assign tick        = ENABLE && (per_q == '0);
    assign div_zero    = (div_q == '0);
    assign bit_idx_inc = bit_idx_q + 5'd1;
    assign acc_sum     = acc_q + ACC_W'(sample_q);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign avg         = 12'(acc_sum >> AVG_LOG2);
    assign target      = {avg, 3'b000};

`ifdef SLEW_LIMIT_EN
    localparam logic signed [15:0] STEP_S = 16'(MAX_STEP);
    localparam logic [14:0]        STEP_U = 15'(MAX_STEP);

    logic signed [15:0] pos_diff;

    // Both operands are at most 15 bits, so a 16-bit signed difference
    // cannot wrap and the stepped result stays within 0..32760.
    always_comb begin
        pos_diff = $signed({1'b0, target}) - $signed({1'b0, pos_q});
        pos_next = target;
        if (pos_diff > STEP_S) begin
            pos_next = pos_q + STEP_U;
        end else if (pos_diff < -STEP_S) begin
            pos_next = pos_q - STEP_U;
        end
    end
`else
    logic unused_max_step;

    assign unused_max_step = ^(16'(MAX_STEP));
    assign pos_next        = target;
`endif

    always_comb begin
        if (!ENABLE || (per_q == PER_LAST)) begin
            per_d = '0;
        end else begin
            per_d = per_q + PER_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ticks arriving outside ST_IDLE are simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tick) state_d = ST_SETUP;
            ST_SETUP: if (div_zero) state_d = ST_SHIFT;
            ST_SHIFT: if (phase_q && div_zero && (bit_idx_q == LAST_BIT)) state_d = ST_HOLD;
            ST_HOLD:  if (div_zero) state_d = ST_ACCUM;
            ST_ACCUM: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_d       = div_q;
        phase_d     = phase_q;
        bit_idx_d   = bit_idx_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        shift_d     = shift_q;
        sample_d    = sample_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        pos_valid_d = 1'b0;
        abort_d     = abort_q;

        // A frame that saw ENABLE low anywhere still completes, but its
        // conversion must not contribute to the average.
        if ((state_q != ST_IDLE) && !ENABLE) begin
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    cs_n_d = 1'b0;
                    div_d  = DIV_LOAD;
                end
            end
            ST_SETUP: begin
                if (div_zero) begin
                    div_d     = DIV_LOAD;
                    phase_d   = 1'b0;
                    bit_idx_d = 5'd0;
                    mosi_d    = mosi_bit(5'd0);
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (!div_zero) begin
                    div_d = div_q - DIV_W'(1);
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                    div_d   = DIV_LOAD;
                end else begin
                    // Last CLK of the high phase: pulse 4 is the null bit,
                    // pulses 5..16 carry D11..D0.
                    if (bit_idx_q >= FIRST_DATA) begin
                        shift_d = {shift_q[10:0], miso_s2_q};
                    end
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = DIV_LOAD;
                    if (bit_idx_q != LAST_BIT) begin
                        bit_idx_d = bit_idx_inc;
                        mosi_d    = mosi_bit(bit_idx_inc);
                    end
                end
            end
            ST_HOLD: begin
                if (div_zero) begin
                    cs_n_d   = 1'b1;
                    sample_d = shift_q;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            ST_ACCUM: begin
                abort_d = 1'b0;
                if (abort_q || !ENABLE) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (cnt_inc == CNT_FULL) begin
                    acc_d       = '0;
                    cnt_d       = '0;
                    pos_d       = pos_next;
                    pos_valid_d = 1'b1;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            miso_s1_q   <= 1'b0;
            miso_s2_q   <= 1'b0;
            per_q       <= '0;
            div_q       <= '0;
            phase_q     <= 1'b0;
            bit_idx_q   <= 5'd0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            shift_q     <= 12'd0;
            sample_q    <= 12'd0;
            acc_q       <= '0;
            cnt_q       <= '0;
            pos_q       <= POS_RESET;
            pos_valid_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            miso_s1_q   <= ADC_MISO;
            miso_s2_q   <= miso_s1_q;
            per_q       <= per_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_idx_q   <= bit_idx_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            shift_q     <= shift_d;
            sample_q    <= sample_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            abort_q     <= abort_d;
        end
    end

    assign ADC_CS_N  = cs_n_q;
    assign ADC_SCLK  = sclk_q;
    assign ADC_MOSI  = mosi_q;
    assign POS       = pos_q;
    assign POS_VALID = pos_valid_q;
    assign SAMPLE    = sample_q;

endmodule

// File: tb/tb_flex_adc_feed.sv
// Testbench for flex_adc_feed: MCP3202 behavioural model plus scoreboards.
// Expected conversions and position words are queued by the stimulus and
// popped by monitors when the DUT ends a frame or pulses POS_VALID.

module tb_flex_adc_feed;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 200;
    localparam int AVG_LOG2      = 2;
    localparam int CHANNEL       = 1;
    localparam int MAX_STEP      = 512;
    localparam int EXP_MOSI      = 32'h0B | (CHANNEL << 2);
    localparam int POS_RST       = 16384;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        ADC_MISO = 1'b0;
    logic        ADC_CS_N;
    logic        ADC_SCLK;
    logic        ADC_MOSI;
    logic [14:0] POS;
    logic        POS_VALID;
    logic [11:0] SAMPLE;

    flex_adc_feed #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .AVG_LOG2     (AVG_LOG2),
        .CHANNEL      (CHANNEL),
        .MAX_STEP     (MAX_STEP)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ENABLE   (ENABLE),
        .ADC_MISO (ADC_MISO),
        .ADC_CS_N (ADC_CS_N),
        .ADC_SCLK (ADC_SCLK),
        .ADC_MOSI (ADC_MOSI),
        .POS      (POS),
        .POS_VALID(POS_VALID),
        .SAMPLE   (SAMPLE)
    );

    always #10 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    int adc_q[$];
    int exp_sample_q[$];
    int exp_pos_q[$];

    int          frames_done = 0;
    int          cs_falls = 0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          gap_cnt = 0;
    int          cur_sample = 0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    logic [16:0] mosi_word = '0;
    bit          ignore_frame = 1'b0;
    int          model_pos = POS_RST;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int step_model(input int cur, input int tgt);
`ifdef SLEW_LIMIT_EN
        if (tgt - cur > MAX_STEP) return cur + MAX_STEP;
        if (cur - tgt > MAX_STEP) return cur - MAX_STEP;
`endif
        return tgt;
    endfunction

    // ADC model and frame monitor. The MCP3202 shifts the null bit out on
    // the falling edge of pulse 3 and D11..D0 on falling edges 4..15.
    always @(negedge CLK) begin
        gap_cnt++;
        if (!ADC_CS_N && cs_prev) begin
            rise_cnt  = 0;
            fall_cnt  = 0;
            mosi_word = '0;
            cs_falls++;
            cur_sample = (adc_q.size() > 0) ? adc_q.pop_front() : 0;
        end
        if (!ADC_CS_N) begin
            if (ADC_SCLK && !sclk_prev) begin
                if (rise_cnt < 17) mosi_word[rise_cnt] = ADC_MOSI;
                rise_cnt++;
            end
            if (!ADC_SCLK && sclk_prev) begin
                if (fall_cnt >= 4 && fall_cnt <= 15) ADC_MISO = cur_sample[15 - fall_cnt];
                else ADC_MISO = 1'b0;
                fall_cnt++;
                gap_cnt = 0;
            end
        end
        if (ADC_CS_N && !cs_prev) begin
            ADC_MISO = 1'b0;
            if (ignore_frame) begin
                ignore_frame = 1'b0;
            end else begin
                check("sclk_pulses", rise_cnt, 17);
                check("mosi_bits", int'(mosi_word), EXP_MOSI);
                check("cs_hold_cycles", gap_cnt, CLK_DIV);
                if (exp_sample_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sample: unexpected frame, SAMPLE=%0d", SAMPLE);
                end else begin
                    check("sample", int'(SAMPLE), exp_sample_q.pop_front());
                end
                frames_done++;
            end
        end
        cs_prev   = ADC_CS_N;
        sclk_prev = ADC_SCLK;
    end

    always @(negedge CLK) begin
        if (POS_VALID) begin
            if (exp_pos_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pos_valid: unexpected pulse, POS=%0d", POS);
            end else begin
                check("pos", int'(POS), exp_pos_q.pop_front());
            end
        end
    end

    task automatic reset_dut();
        ENABLE = 1'b0;
        RST_N  = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        model_pos = POS_RST;
    endtask

    task automatic wait_frames(input int target, input string name);
        int budget = 0;
        while (frames_done < target && budget < 2000) begin
            @(posedge CLK);
            budget++;
        end
        if (frames_done < target) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout, frames %0d, expected %0d", name, frames_done, target);
        end
    endtask

    task automatic run_avg(input int s0, input int s1, input int s2, input int s3,
                           input int tgt, input string name);
        int base = frames_done;
        int s[4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            adc_q.push_back(s[i]);
            exp_sample_q.push_back(s[i]);
        end
        model_pos = step_model(model_pos, tgt);
        exp_pos_q.push_back(model_pos);
        ENABLE = 1'b1;
        wait_frames(base + 4, name);
        repeat (10) @(posedge CLK);
        #1 ENABLE = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check({name, "_pending"}, exp_pos_q.size(), 0);
        check({name, "_hold"}, int'(POS), model_pos);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int falls;
        int budget;
        int started;
        int n_upd;

        // Reset values while held in reset.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cs_n", int'(ADC_CS_N), 1);
        check("rst_sclk", int'(ADC_SCLK), 0);
        check("rst_mosi", int'(ADC_MOSI), 0);
        check("rst_pos", int'(POS), POS_RST);
        check("rst_pos_valid", int'(POS_VALID), 0);
        check("rst_sample", int'(SAMPLE), 0);
        RST_N = 1'b1;
        repeat (4) @(posedge CLK);

        // Reset in the middle of SHIFT, during the high phase of pulse 3.
        reset_dut();
        adc_q.push_back(12'h555);
        ignore_frame = 1'b1;
        ENABLE = 1'b1;
        budget = 0;
        while (!(ADC_SCLK && !ADC_CS_N && rise_cnt == 4) && budget < 400) begin
            @(negedge CLK);
            budget++;
        end
        check("midshift_reached", int'(ADC_SCLK && ADC_MOSI), 1);
        #3;
        RST_N  = 1'b0;
        ENABLE = 1'b0;
        #1;
        check("midrst_cs_n", int'(ADC_CS_N), 1);
        check("midrst_sclk", int'(ADC_SCLK), 0);
        check("midrst_mosi", int'(ADC_MOSI), 0);
        check("midrst_pos", int'(POS), POS_RST);
        check("midrst_pos_valid", int'(POS_VALID), 0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        falls = cs_falls;
        repeat (300) @(posedge CLK);
        check("no_frame_without_tick", cs_falls, falls);
        adc_q.push_back(12'h123);
        exp_sample_q.push_back(12'h123);
        base = frames_done;
        #1 ENABLE = 1'b1;
        started = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (!ADC_CS_N) started = 1;
        end
        check("frame_starts_on_tick", started, 1);
        wait_frames(base + 1, "first_frame");
        repeat (10) @(posedge CLK);
        #1 ENABLE = 1'b0;

        // Single frame, 0xABC on channel 1.
        reset_dut();
        adc_q.push_back(12'hABC);
        exp_sample_q.push_back(12'hABC);
        base = frames_done;
        ENABLE = 1'b1;
        wait_frames(base + 1, "single_frame");
        repeat (10) @(posedge CLK);
        #1 ENABLE = 1'b0;
        check("single_pos_hold", int'(POS), POS_RST);

        // Averaging: (100+200+300+400)/4 = 250, scaled by 8 -> 2000.
        reset_dut();
        run_avg(100, 200, 300, 400, 2000, "avg_ramp");

        // Full scale and zero.
        reset_dut();
        run_avg(4095, 4095, 4095, 4095, 32760, "full_scale");
        run_avg(0, 0, 0, 0, 0, "zero_scale");

        // Constant full-scale input from reset.
        reset_dut();
`ifdef SLEW_LIMIT_EN
        n_upd = 32;
`else
        n_upd = 2;
`endif
        for (int i = 0; i < n_upd; i++) begin
            run_avg(4095, 4095, 4095, 4095, 32760, "slew");
        end
        check("slew_final", int'(POS), 32760);

        // ENABLE dropped during pulse 8 of frame 2.
        reset_dut();
        adc_q.push_back(1000);
        exp_sample_q.push_back(1000);
        adc_q.push_back(2000);
        exp_sample_q.push_back(2000);
        base = frames_done;
        ENABLE = 1'b1;
        wait_frames(base + 1, "drop_frame1");
        budget = 0;
        while (!(!ADC_CS_N && rise_cnt == 9) && budget < 400) begin
            @(negedge CLK);
            budget++;
        end
        check("drop_at_pulse8", rise_cnt, 9);
        #1 ENABLE = 1'b0;
        wait_frames(base + 2, "drop_frame2");
        repeat (10) @(posedge CLK);
        #1;
        check("drop_cs_n_high", int'(ADC_CS_N), 1);
        check("drop_pos_hold", int'(POS), POS_RST);
        run_avg(1000, 1000, 1000, 1000, 8000, "after_drop");

        check("exp_sample_left", exp_sample_q.size(), 0);
        check("exp_pos_left", exp_pos_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
